// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the lab ALU sharing controller: FSM encoding,
// ALU function codes and the highest legal function code.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] F_ADD       = 3'd0;
  localparam logic [2:0] F_PLUS      = 3'd1;
  localparam logic [2:0] F_XNOR_NAND = 3'd2;
  localparam logic [2:0] F_ORRED     = 3'd3;
  localparam logic [2:0] F_PARITY    = 3'd4;
  localparam logic [2:0] F_CONCAT    = 3'd5;

  localparam int FUNC_MAX = 5;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick. ptr names the requester that wins a tie.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] win,
  output logic       any_req
);

  always_comb begin
    win     = req;
    any_req = |req;
    if (req == 2'b11) begin
      win = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Sequences one external combinational ALU between two requesters:
// grant, drive registered operands, capture result, hand it back.
//
//   state | meaning
//   IDLE  | waiting for a request; ALU operands hold their last value
//   DRIVE | winner's operands are on the ALU; result captured at end
//   DONE  | response valid for the winner until it is accepted
module alu_share_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int OPW      = 4,
  parameter int RESW     = 8,
  parameter int FUNCW    = 3,
  parameter int FUNC_MAX = alu_ctrl_pkg::FUNC_MAX
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [OPW-1:0]   a0,
  input  logic [OPW-1:0]   b0,
  input  logic [FUNCW-1:0] sel0,
  input  logic [OPW-1:0]   a1,
  input  logic [OPW-1:0]   b1,
  input  logic [FUNCW-1:0] sel1,
  output logic [1:0]       gnt,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [RESW-1:0]  rsp_data,
  output logic             rsp_err,
  output logic [OPW-1:0]   alu_a,
  output logic [OPW-1:0]   alu_b,
  output logic [FUNCW-1:0] alu_sel,
  input  logic [RESW-1:0]  alu_result,
  output logic             busy,
  output logic [7:0]       op_count
);

  state_t     state;
  logic       ptr;
  logic       owner;
  logic [1:0] win;
  logic       any_req;

  rr_arbiter2 u_arb (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .any_req (any_req)
  );

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      gnt       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      busy      <= 1'b0;
      op_count  <= '0;
    end else begin
      gnt <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner <= win[1];
            gnt   <= win;
            busy  <= 1'b1;
            state <= DRIVE;
            if (win[1]) begin
              alu_a   <= a1;
              alu_b   <= b1;
              alu_sel <= sel1;
              rsp_err <= (sel1 > FUNCW'(FUNC_MAX));
            end else begin
              alu_a   <= a0;
              alu_b   <= b0;
              alu_sel <= sel0;
              rsp_err <= (sel0 > FUNCW'(FUNC_MAX));
            end
          end
        end
        DRIVE: begin
          rsp_data  <= alu_result;
          rsp_valid <= owner ? 2'b10 : 2'b01;
          state     <= DONE;
        end
        DONE: begin
          // Only the owner's ready counts; the other requester has nothing pending.
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            op_count  <= op_count + 8'd1;
            ptr       <= ~owner;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural model of the lab ALU.
module tb_alu_share_arbiter;
  import alu_ctrl_pkg::*;

  logic       clk_sys = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = '0;
  logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [2:0] sel0 = '0, sel1 = '0;
  logic [1:0] gnt, rsp_valid;
  logic [1:0] rsp_ready = '0;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [7:0] alu_result;
  logic       busy;
  logic [7:0] op_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_sys = ~clk_sys;

  alu_share_arbiter dut (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .req        (req),
    .a0         (a0),
    .b0         (b0),
    .sel0       (sel0),
    .a1         (a1),
    .b1         (b1),
    .sel1       (sel1),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .busy       (busy),
    .op_count   (op_count)
  );

  // Lab ALU model; illegal codes return zero.
  always_comb begin
    alu_result = 8'h00;
    case (alu_sel)
      F_ADD:       alu_result = {4'h0, alu_a} + {4'h0, alu_b};
      F_PLUS:      alu_result = {4'h0, alu_a} + {4'h0, alu_b} + 8'd1;
      F_XNOR_NAND: alu_result = {~(alu_a & alu_b), ~(alu_a ^ alu_b)};
      F_ORRED:     alu_result = {4'h0, {4{|(alu_a | alu_b)}}};
      F_PARITY:    alu_result = {7'h0, ^{alu_a, alu_b}};
      F_CONCAT:    alu_result = {alu_a, ~alu_b};
      default:     alu_result = 8'h00;
    endcase
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // One operation from a single requester with rsp_ready already high.
  task automatic run_op(input int who, input logic [3:0] a, input logic [3:0] b,
                        input logic [2:0] sel, input logic [7:0] exp_data,
                        input logic exp_err, input string tag);
    logic [1:0] oh;
    int waited;
    oh = (who == 1) ? 2'b10 : 2'b01;
    if (who == 1) begin a1 = a; b1 = b; sel1 = sel; end
    else begin a0 = a; b0 = b; sel0 = sel; end
    req = oh;
    waited = 0;
    tick();
    while (gnt == 2'b00 && waited < 8) begin
      tick();
      waited++;
    end
    check_eq({tag, "_gnt"}, int'(gnt), int'(oh));
    req = 2'b00;
    tick();
    check_eq({tag, "_valid"}, int'(rsp_valid), int'(oh));
    check_eq({tag, "_data"}, int'(rsp_data), int'(exp_data));
    check_eq({tag, "_err"}, int'(rsp_err), int'(exp_err));
    tick();
    check_eq({tag, "_clr"}, int'(rsp_valid), 0);
  endtask

  initial begin
    logic [1:0] seen [4];
    int ng;
    int guard;

    tick();
    tick();
    check_eq("rst_gnt", int'(gnt), 0);
    check_eq("rst_valid", int'(rsp_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_count", int'(op_count), 0);
    check_eq("rst_alu", int'({alu_a, alu_b, alu_sel}), 0);
    check_eq("rst_data", int'(rsp_data), 0);
    rst = 1'b0;
    rsp_ready = 2'b11;

    // First op: exact cycle latency.
    a0 = 4'd3; b0 = 4'd5; sel0 = F_ADD; req = 2'b01;
    tick();
    check_eq("first_gnt", int'(gnt), 1);
    check_eq("first_busy", int'(busy), 1);
    check_eq("first_alu", int'({alu_a, alu_b, alu_sel}), int'({4'd3, 4'd5, 3'd0}));
    req = 2'b00;
    tick();
    check_eq("first_valid", int'(rsp_valid), 1);
    check_eq("first_data", int'(rsp_data), 8'h08);
    check_eq("first_err", int'(rsp_err), 0);
    check_eq("first_gnt_pulse", int'(gnt), 0);
    tick();
    check_eq("first_count", int'(op_count), 1);
    check_eq("first_idle", int'(busy), 0);
    check_eq("alu_hold", int'({alu_a, alu_b, alu_sel}), int'({4'd3, 4'd5, 3'd0}));

    run_op(1, 4'd3, 4'd5, F_XNOR_NAND, 8'hE9, 1'b0, "r1_xn");
    run_op(1, 4'd3, 4'd5, F_CONCAT,    8'h3A, 1'b0, "r1_cat");
    run_op(1, 4'd3, 4'd5, F_ORRED,     8'h0F, 1'b0, "r1_or");
    check_eq("count_4", int'(op_count), 4);

    // Both saturated, pointer at requester 0: grants must alternate.
    a0 = 4'd1; b0 = 4'd2; sel0 = F_ADD;
    a1 = 4'd4; b1 = 4'd4; sel1 = F_ADD;
    req = 2'b11;
    ng = 0;
    guard = 0;
    while (ng < 4 && guard < 40) begin
      tick();
      guard++;
      if (gnt != 2'b00) begin
        seen[ng] = gnt;
        ng++;
      end
    end
    req = 2'b00;
    check_eq("both_ngrants", ng, 4);
    if (ng == 4) begin
      check_eq("both_g0", int'(seen[0]), 1);
      check_eq("both_g1", int'(seen[1]), 2);
      check_eq("both_g2", int'(seen[2]), 1);
      check_eq("both_g3", int'(seen[3]), 2);
    end
    tick();
    check_eq("both_last_data", int'(rsp_data), 8'h08);
    tick();
    check_eq("both_count", int'(op_count), 8);

    run_op(0, 4'd3, 4'd5, 3'd6, 8'h00, 1'b1, "illegal6");

    // Backpressure on requester 0 while requester 1 waits.
    rsp_ready = 2'b10;
    a0 = 4'd7; b0 = 4'd8; sel0 = F_ADD; req = 2'b01;
    tick();
    check_eq("bp_gnt", int'(gnt), 1);
    a1 = 4'd2; b1 = 4'd3; sel1 = F_ADD; req = 2'b10;
    tick();
    for (int i = 0; i < 5; i++) begin
      check_eq("bp_valid", int'(rsp_valid), 1);
      check_eq("bp_data", int'(rsp_data), 8'h0F);
      check_eq("bp_busy", int'(busy), 1);
      check_eq("bp_nognt", int'(gnt), 0);
      tick();
    end
    check_eq("bp_count_hold", int'(op_count), 9);
    rsp_ready = 2'b11;
    tick();
    check_eq("bp_accept_gnt", int'(gnt), 0);
    check_eq("bp_count", int'(op_count), 10);
    tick();
    check_eq("bp_next_gnt", int'(gnt), 2);
    req = 2'b00;
    tick();
    check_eq("bp_next_data", int'(rsp_data), 8'h05);
    tick();

    // Move pointer to requester 1, then reset in DRIVE.
    run_op(0, 4'd1, 4'd1, F_ADD, 8'h02, 1'b0, "pre_rst");
    req = 2'b01;
    tick();
    check_eq("drv_gnt", int'(gnt), 1);
    rst = 1'b1;
    req = 2'b00;
    tick();
    rst = 1'b0;
    check_eq("drvrst_valid", int'(rsp_valid), 0);
    check_eq("drvrst_count", int'(op_count), 0);
    check_eq("drvrst_busy", int'(busy), 0);
    tick();
    tick();
    check_eq("drvrst_noresp", int'(rsp_valid), 0);
    req = 2'b11;
    tick();
    check_eq("drvrst_ptr", int'(gnt), 1);
    req = 2'b00;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares the single 6-function lab ALU (func 0..5, 4-bit A/B in, 8-bit result out) between two requesters, for example the switch/KEY front end and a self-test sequencer.
- Round-robin arbitration chooses one requester at a time.
- The winner's operands are registered and driven into the ALU.
- The ALU result is captured one cycle later.
- The result is returned to the winner over a valid/ready response handshake.
- The ALU itself stays external and combinational; this block only sequences it.

Parameters:
- OPW, 4, operand width of A and B.
- RESW, 8, ALU result width.
- FUNCW, 3, function-select width.
- FUNC_MAX, 5, highest legal function code.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- req  in  2  per-requester operation request, level-sensitive.
- a0, b0  in  OPW  requester 0 operands.
- sel0  in  FUNCW  requester 0 function code.
- a1, b1  in  OPW  requester 1 operands.
- sel1  in  FUNCW  requester 1 function code.
- gnt  out  2  one-hot, one-cycle pulse: operands of that requester were latched.
- rsp_valid  out  2  one-hot: response pending for that requester.
- rsp_ready  in  2  per-requester response accept.
- rsp_data  out  RESW  captured ALU result; shared by both requesters.
- rsp_err  out  1  the function code of the pending response exceeded FUNC_MAX.
- alu_a, alu_b  out  OPW  operands to the ALU.
- alu_sel  out  FUNCW  function select to the ALU.
- alu_result  in  RESW  combinational ALU output.
- busy  out  1  high in any state other than IDLE.
- op_count  out  8  number of completed (accepted) operations; wraps 255 -> 0.

Behaviour:
- Reset (sampled on Clock edge, takes priority over everything):
  - state = IDLE, rr pointer = requester 0.
  - Outputs cleared: gnt=0, rsp_valid=0, rsp_data=0, rsp_err=0, alu_a/alu_b/alu_sel=0, busy=0, op_count=0.
  - A reset in DRIVE or DONE discards the in-flight operation; no response is ever issued for it.
- FSM states: IDLE, DRIVE, DONE.
- IDLE, with req != 0 at edge N:
  - Winner chosen by rr_arbiter2: if both requesters are requesting, the pointer requester wins; otherwise the sole requester wins.
  - The winner's a/b/sel are latched into alu_a/alu_b/alu_sel.
  - rsp_err is latched as (sel > FUNC_MAX); winner id is stored.
  - gnt[winner]=1 during cycle N+1 only; state -> DRIVE.
- IDLE, with req == 0: remain in IDLE.
- DRIVE (cycle N+1):
  - ALU inputs are stable from the registers.
  - At edge N+1, rsp_data <= alu_result; state -> DONE.
- DONE (from cycle N+2):
  - rsp_valid[winner]=1; rsp_data and rsp_err are held stable.
  - When rsp_ready[winner]=1, the response is accepted at that edge:
    - rsp_valid clears;
    - op_count increments;
    - rr pointer <= the other requester;
    - state -> IDLE.
  - rsp_ready of the non-winner is ignored.
- Minimum latency: req sampled at edge N -> rsp_valid in cycle N+2. With rsp_ready already high, the next arbitration happens at edge N+3.
- Requester obligations:
  - Hold a/b/sel stable while req is high and until gnt is seen.
  - A req still high when the FSM returns to IDLE is treated as a new request.
- Illegal sel (6, 7):
  - Still issued to the ALU; the ALU returns 0.
  - rsp_err=1 with rsp_data as captured.
- alu_a/alu_b/alu_sel hold their last value in IDLE. They change only on grant.
- Starvation bound: with both requesters saturated, grants alternate strictly.

Decomposition:
- Package alu_ctrl_pkg holds:
  - state encoding IDLE=2'd0, DRIVE=2'd1, DONE=2'd2;
  - function-code constants F_ADD=0, F_PLUS=1, F_XNOR_NAND=2, F_ORRED=3, F_PARITY=4, F_CONCAT=5;
  - FUNC_MAX.
- Sub-module rr_arbiter2: combinational 2-way round-robin pick from req and the pointer. It outputs a one-hot winner and any_req.

Test Plan:
- Reset, then requester 0 alone with a0=3, b0=5, sel0=0; rsp_ready0 held high -> gnt=2'b01 in cycle 1, rsp_valid=2'b01 in cycle 2, rsp_data=8'h08, rsp_err=0, op_count=1.
- Requester 1 alone with a1=3, b1=5, sel1=2 -> rsp_data=8'hE9; then sel1=5 -> 8'h3A; then sel1=3 -> 8'h0F.
- Both req held high for 4 operations, pointer starting at requester 0 -> gnt sequence 01, 10, 01, 10; op_count=4.
- Requester 0 with sel0=6 -> rsp_err=1, rsp_data=8'h00.
- Backpressure: rsp_ready0 held low for 5 cycles -> rsp_valid and rsp_data stay stable, busy=1, no new gnt even though req1 is high; raising rsp_ready0 leads to gnt=2'b10 two edges later.
- Reset asserted during DRIVE -> next cycle: rsp_valid=0, op_count=0, state IDLE, pointer at requester 0, no response issued.
